// File: rtl/jesd204_tx_pkg.sv
// Shared types for the jesd204_tx source-side blocks.
package jesd204_tx_pkg;

   typedef logic [31:0] lane_word_t;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } src_fifo_state_t;

endpackage

// File: rtl/jesd204_tx_sdpram.sv
// Simple dual-port register array: one write port, one registered read port whose
// output can be synchronously loaded with zero.
module jesd204_tx_sdpram
   import jesd204_tx_pkg::*;
#(
   parameter int unsigned Lanes = 4,
   parameter int unsigned Depth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic [$clog2(Depth)-1:0]   wr_addr_i,
   input  lane_word_t [Lanes-1:0]     wr_data_i,
   input  logic                       rd_en_i,
   input  logic [$clog2(Depth)-1:0]   rd_addr_i,
   input  logic                       rd_clr_i,
   output lane_word_t [Lanes-1:0]     rd_data_o
);

   lane_word_t [Lanes-1:0] mem_q [Depth];
   lane_word_t [Lanes-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else if (rd_clr_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jesd204_tx_src_fifo.sv
// Elastic source buffer feeding jesd204_tx DI: primes to THRESH after RDY, then pops one
// word per cycle; an empty pop flags a sticky underflow and drops back to priming.
module jesd204_tx_src_fifo
   import jesd204_tx_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned THRESH = 8
) (
   input  logic                       CLK,
   input  logic                       RST_n,
   input  logic                       S_VALID,
   output logic                       S_READY,
   input  lane_word_t [LANES-1:0]     S_DATA,
   input  logic                       RDY,
   output lane_word_t [LANES-1:0]     DI,
   output logic [$clog2(DEPTH):0]     LEVEL,
   output logic                       UNDERFLOW,
   input  logic                       CLR_ERR
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] THRESH_L = PW'(THRESH);

   src_fifo_state_t state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            underflow_q, underflow_d;

   logic            full, empty, push, wr_en, pop, flush, uf_set;
   logic [PW-1:0]   prime_fill;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   // Registered-only decode: no path from pop or RDY into the upstream handshake.
   assign S_READY = !full || (state_q == IDLE);
   assign push    = S_VALID && S_READY;
   assign wr_en   = push && !flush;
   assign LEVEL   = wr_ptr_q - rd_ptr_q;

   // PRIME never pops or flushes, so the post-edge fill is just LEVEL plus this push;
   // comparing it lets RUN begin on the very edge that reaches THRESH.
   assign prime_fill = LEVEL + PW'(push);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      flush   = 1'b0;
      uf_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            flush = 1'b1;
            state_d = PRIME;
         end
         PRIME: begin
            if (prime_fill >= THRESH_L) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (empty) begin
               uf_set  = 1'b1;
               state_d = PRIME;
            end else begin
               pop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Link drop overrides everything, including a pending pop or underflow.
      if (!RDY) begin
         state_d = IDLE;
         pop     = 1'b0;
         uf_set  = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   assign underflow_d = uf_set || (underflow_q && !CLR_ERR);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         underflow_q <= underflow_d;
      end
   end

   assign UNDERFLOW = underflow_q;

   // Any cycle without a pop loads zero, so DI is 0 outside of active streaming.
   jesd204_tx_sdpram #(
      .Lanes (LANES),
      .Depth (DEPTH)
   ) u_ram (
      .clk_i     (CLK),
      .rst_ni    (RST_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (S_DATA),
      .rd_en_i   (pop),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_clr_i  (!pop),
      .rd_data_o (DI)
   );

endmodule

// File: tb/tb_jesd204_tx_src_fifo.sv
// Scoreboard bench for jesd204_tx_src_fifo: THRESH=8 main instance plus a THRESH=16
// instance for the full-buffer case.
module tb_jesd204_tx_src_fifo;
   import jesd204_tx_pkg::*;

   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
   localparam int unsigned DW    = LANES * 32;

   typedef lane_word_t [LANES-1:0] word_t;

   logic          CLK = 1'b0;
   logic          RST_n = 1'b0;

   logic          s_valid = 1'b0, rdy = 1'b0, clr_err = 1'b0;
   word_t         s_data = '0;
   logic          s_ready, underflow;
   word_t         di;
   logic [LW-1:0] level;

   logic          s_valid16 = 1'b0, rdy16 = 1'b0, clr16 = 1'b0;
   word_t         s_data16 = '0;
   logic          s_ready16, underflow16;
   word_t         di16;
   logic [LW-1:0] level16;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_seen  = 0;
   word_t exp_q[$];

   always #5 CLK = ~CLK;

   jesd204_tx_src_fifo #(.LANES(LANES), .DEPTH(DEPTH), .THRESH(8)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .S_VALID   (s_valid),
      .S_READY   (s_ready),
      .S_DATA    (s_data),
      .RDY       (rdy),
      .DI        (di),
      .LEVEL     (level),
      .UNDERFLOW (underflow),
      .CLR_ERR   (clr_err)
   );

   jesd204_tx_src_fifo #(.LANES(LANES), .DEPTH(DEPTH), .THRESH(16)) dut16 (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .S_VALID   (s_valid16),
      .S_READY   (s_ready16),
      .S_DATA    (s_data16),
      .RDY       (rdy16),
      .DI        (di16),
      .LEVEL     (level16),
      .UNDERFLOW (underflow16),
      .CLR_ERR   (clr16)
   );

   function automatic word_t mkw(input int unsigned k);
      word_t w;
      for (int l = 0; l < LANES; l++) begin
         w[l] = (32'(k) * 32'h01010101) ^ (32'(l) << 28);
      end
      return w;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: every non-zero DI word must be the next expected word in order.
   always @(negedge CLK) begin
      word_t e;
      if (RST_n && di != '0) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected: got %h required no word", di);
         end else begin
            e = exp_q.pop_front();
            check("mon_di", DW'(di), DW'(e));
            n_seen++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t ew;
      #2;
      check("rst_di", DW'(di), DW'(0));
      check("rst_level", DW'(level), DW'(0));
      check("rst_ready", DW'(s_ready), DW'(1));
      check("rst_uf", DW'(underflow), DW'(0));
      @(posedge CLK);
      #1 RST_n = 1'b1;

      // RDY low: pushes accepted and discarded.
      for (int k = 1; k <= 5; k++) begin
         s_valid = 1'b1;
         s_data  = mkw(50 + k);
         step();
         check("idle_level", DW'(level), DW'(0));
         check("idle_ready", DW'(s_ready), DW'(1));
         check("idle_di", DW'(di), DW'(0));
      end
      s_valid = 1'b0;

      // Prime to 8 then stream with a push every cycle.
      rdy = 1'b1;
      step();
      for (int k = 1; k <= 20; k++) begin
         s_valid = 1'b1;
         s_data  = mkw(k);
         exp_q.push_back(mkw(k));
         step();
         check("stream_level", DW'(level), DW'((k < 8) ? k : 8));
         ew = (k <= 8) ? word_t'(0) : mkw(k - 8);
         check("stream_di", DW'(di), DW'(ew));
      end

      // Link drop mid-stream.
      s_valid = 1'b0;
      rdy     = 1'b0;
      step();
      check("rdyfall_di", DW'(di), DW'(0));
      check("rdyfall_level1", DW'(level), DW'(8));
      step();
      check("rdyfall_level2", DW'(level), DW'(0));
      check("rdyfall_pending", DW'(exp_q.size()), DW'(8));
      exp_q.delete();

      // Re-prime from fresh data, then starve it.
      rdy = 1'b1;
      step();
      for (int k = 1; k <= 8; k++) begin
         s_valid = 1'b1;
         s_data  = mkw(100 + k);
         exp_q.push_back(mkw(100 + k));
         step();
      end
      check("reprime_level", DW'(level), DW'(8));
      s_valid = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         step();
         check("drain_di", DW'(di), DW'(mkw(100 + j)));
      end
      clr_err = 1'b1;
      step();
      check("uf_set_wins", DW'(underflow), DW'(1));
      check("uf_di", DW'(di), DW'(0));
      check("uf_level", DW'(level), DW'(0));

      // Resume pushing; underflow held, then cleared.
      for (int k = 1; k <= 12; k++) begin
         s_valid = 1'b1;
         s_data  = mkw(200 + k);
         clr_err = (k == 2);
         exp_q.push_back(mkw(200 + k));
         step();
         check("resume_uf", DW'(underflow), DW'((k == 1) ? 1 : 0));
         check("resume_level", DW'(level), DW'((k < 8) ? k : 8));
         ew = (k <= 8) ? word_t'(0) : mkw(200 + k - 8);
         check("resume_di", DW'(di), DW'(ew));
      end
      s_valid = 1'b0;
      clr_err = 1'b0;

      // Asynchronous reset mid-RUN.
      @(negedge CLK);
      #1 RST_n = 1'b0;
      #1;
      check("arst_di", DW'(di), DW'(0));
      check("arst_level", DW'(level), DW'(0));
      check("arst_ready", DW'(s_ready), DW'(1));
      check("arst_uf", DW'(underflow), DW'(0));
      exp_q.delete();
      check("seen_words", DW'(n_seen), DW'(24));
      rdy = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_n = 1'b1;

      // THRESH=16: fill to full, 17th word refused, then stream from word 1.
      rdy16 = 1'b1;
      step();
      for (int k = 1; k <= 16; k++) begin
         check("full_ready_before", DW'(s_ready16), DW'(1));
         s_valid16 = 1'b1;
         s_data16  = mkw(300 + k);
         step();
      end
      check("full_level", DW'(level16), DW'(16));
      check("full_ready", DW'(s_ready16), DW'(0));
      check("full_di", DW'(di16), DW'(0));
      s_data16 = mkw(317);
      step();
      s_valid16 = 1'b0;
      check("full_level_after", DW'(level16), DW'(15));
      check("full_first_di", DW'(di16), DW'(mkw(301)));
      for (int j = 2; j <= 16; j++) begin
         step();
         check("full_stream_di", DW'(di16), DW'(mkw(300 + j)));
      end
      step();
      check("full_end_di", DW'(di16), DW'(0));
      check("full_end_uf", DW'(underflow16), DW'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
